// File: rtl/det_share_ctrl.sv
`default_nettype none
// det_share_ctrl: time-shares one external 11011 Mealy detector among four serial requesters,
// with per-requester saturating hit counters. Define DET_SHARE_PRIO_EN to give requester 0 fixed priority.
module det_share_ctrl #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       din,
  output logic [3:0]       gnt,
  output logic             det_clr,
  output logic             det_vld,
  output logic             det_bit,
  input  logic             det_hit,
  output logic             done,
  input  logic [1:0]       cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  localparam logic [7:0]       LAST_BIT = 8'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t           state, state_nxt;
  logic [1:0]       g, g_nxt;
  logic [1:0]       last;
  logic [7:0]       bit_cnt, bit_cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       arb_req;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             found;

`ifdef DET_SHARE_PRIO_EN
  assign arb_req = {req[3:1], 1'b0};
`else
  assign arb_req = req;
`endif

  // Round-robin search upward from last+1; i=4 wraps back to last itself.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && arb_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`ifdef DET_SHARE_PRIO_EN
    if (req[0]) winner = 2'd0;
`endif
  end

  always_comb begin
    state_nxt   = state;
    g_nxt       = g;
    gnt_nxt     = gnt;
    bit_cnt_nxt = bit_cnt;
    det_clr     = 1'b0;
    det_vld     = 1'b0;
    det_bit     = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          g_nxt     = winner;
          gnt_nxt   = 4'b0001 << winner;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        det_clr     = 1'b1;
        bit_cnt_nxt = '0;
        state_nxt   = STREAM;
      end
      STREAM: begin
        det_vld = req[g];
        det_bit = din[g];
        if (!req[g]) begin
          state_nxt = DONE;
        end else begin
          bit_cnt_nxt = bit_cnt + 8'd1;
          if (bit_cnt == LAST_BIT) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      g       <= '0;
      gnt     <= '0;
      bit_cnt <= '0;
      last    <= 2'd3;
    end else begin
      state   <= state_nxt;
      g       <= g_nxt;
      gnt     <= gnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      if (state == DONE) last <= g;
    end
  end

  // Clear beats a coincident hit; hits outside a valid bit are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (det_vld && det_hit && (cnt[g] != CNT_MAX)) begin
      cnt[g] <= cnt[g] + CNT_ONE;
    end
  end

  assign hit_cnt = cnt[cnt_sel];

endmodule
`default_nettype wire

// File: tb/tb_det_share_ctrl.sv
`default_nettype none
// Bench for det_share_ctrl: directed scenarios plus randomized bursts, checked against a burst-level model
// and an environment model of the 11011 detector.
module tb_det_share_ctrl;
  localparam int BL   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic [3:0]    din = '0;
  logic [3:0]    gnt;
  logic          det_clr, det_vld, det_bit, det_hit, done;
  logic [1:0]    cnt_sel = '0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] hit_cnt;

  logic          hit_force = 1'b0;
  logic [3:0]    hist;
  int            nhist;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int last_g = 3;
  int exp_cnt[4];

  always #10 clk = ~clk;

  det_share_ctrl #(.BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
    .det_clr(det_clr), .det_vld(det_vld), .det_bit(det_bit), .det_hit(det_hit),
    .done(done), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
  );

  // External overlapping 11011 Mealy detector, restarted by det_clr.
  always @(posedge clk or posedge rst) begin
    if (rst || det_clr) begin
      hist  <= '0;
      nhist <= 0;
    end else if (det_vld) begin
      hist  <= {hist[2:0], det_bit};
      nhist <= nhist + 1;
    end
  end
  assign det_hit = hit_force | ((nhist >= 4) && ({hist, det_bit} == 5'b11011));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] m);
`ifdef DET_SHARE_PRIO_EN
    if (m[0]) return 0;
    m[0] = 1'b0;
`endif
    for (int s = 1; s <= 4; s++)
      if (m[(last + s) % 4]) return (last + s) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    last_g = 3;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
  endtask

  // Entered and left at a negedge in an IDLE cycle.
  task automatic burst(input logic [3:0] mask, input int abort_at, input logic [BL-1:0] pat,
                       input bit use_pat, input bit force_hit, input int clr_at);
    int w;
    bit ab;
    bit hit;
    bit q[$];
    logic [3:0] oh;
    w  = rr_pick(last_g, mask);
    oh = 4'b0001 << w;
    ab = 1'b0;
    req = mask;
    @(posedge clk); @(negedge clk);
    chk($sformatf("clear_gnt w=%0d", w), gnt, oh);
    chk("clear_pulse", det_clr, 1);
    chk("clear_vld", det_vld, 0);
    @(posedge clk);
    for (int k = 0; k < BL; k++) begin
      @(negedge clk);
      din = 4'($urandom);
      if (use_pat) din[w] = pat[BL-1-k];
      hit_force = force_hit;
      cnt_clr   = (k == clr_at);
      if (k == abort_at) begin
        req[w] = 1'b0;
        ab     = 1'b1;
      end
      #1;
      chk($sformatf("stream_vld k=%0d", k), det_vld, !ab);
      chk("stream_clr", det_clr, 0);
      chk("stream_done", done, 0);
      if (!ab) begin
        chk($sformatf("stream_bit k=%0d", k), det_bit, din[w]);
        q.push_back(din[w]);
        hit = force_hit || (q.size() >= 5 && q[$-4] && q[$-3] && !q[$-2] && q[$-1] && q[$]);
      end else begin
        hit = 1'b0;
      end
      if (cnt_clr) foreach (exp_cnt[i]) exp_cnt[i] = 0;
      else if (hit && exp_cnt[w] < CMAX) exp_cnt[w]++;
      @(posedge clk);
      if (ab) break;
    end
    @(negedge clk);
    hit_force = 1'b0;
    cnt_clr   = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_gnt", gnt, oh);
    chk("done_vld", det_vld, 0);
    @(posedge clk); @(negedge clk);
    chk("idle_gnt", gnt, 0);
    chk("idle_done", done, 0);
    chk("idle_clr", det_clr, 0);
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      chk($sformatf("hit_cnt sel=%0d", i), hit_cnt, exp_cnt[i]);
    end
    last_g = w;
  endtask

  initial begin
    logic [3:0] m;
    int ab_at, clr_at;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_det_clr", det_clr, 0);
    chk("rst_det_vld", det_vld, 0);
    chk("rst_det_bit", det_bit, 0);
    chk("rst_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      chk($sformatf("rst_hit_cnt sel=%0d", i), hit_cnt, 0);
    end
    rst = 1'b0;

    burst(4'b0010, -1, 16'b1101101101101101, 1'b1, 1'b0, -1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) burst(4'b1111, -1, '0, 1'b0, 1'b0, -1);

    burst(4'b0100, 5, '0, 1'b0, 1'b0, -1);

    burst(4'b1000, -1, '0, 1'b0, 1'b1, -1);
    burst(4'b1000, 4, '0, 1'b0, 1'b1, -1);
    burst(4'b1000, 1, '0, 1'b0, 1'b1, 0);

    repeat (16) begin
      do m = 4'($urandom); while (m == 4'b0000);
      ab_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
      clr_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
      burst(m, ab_at, 16'($urandom | $urandom), 1'($urandom), 1'b0, clr_at);
    end

    repeat (4) burst(4'b1001, -1, '0, 1'b0, 1'b0, -1);

    // Asynchronous reset in the middle of a stream.
    req = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("mid_gnt", gnt, 4'b0100);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_vld", det_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_vld", det_vld, 0);
    chk("async_bit", det_bit, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    chk("rst_hold_done", done, 0);
    rst = 1'b0;
    req = 4'b0000;
    model_reset();
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_gnt", gnt, 0);
    burst(4'b1111, -1, '0, 1'b0, 1'b0, -1);

    req = 4'b0000;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/det_share_ctrl.md
DET_SHARE_CTRL -- requirements
Module: det_share_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, giving the number of serial bits per burst; legal range is 2..255.
REQ-002 SHALL have parameter CNT_W, default 4, giving the width of each per-requester hit counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 4 bits: per-requester burst request, level-held.
REQ-006 SHALL have port din, input, 4 bits: per-requester serial data bit.
REQ-007 SHALL have port gnt, output, 4 bits: one-hot registered grant, or all-zero.
REQ-008 SHALL have port det_clr, output, 1 bit: one-cycle restart pulse to the shared 11011 Mealy detector.
REQ-009 SHALL have port det_vld, output, 1 bit: det_bit is valid this cycle.
REQ-010 SHALL have port det_bit, output, 1 bit: serial bit forwarded to the detector.
REQ-011 SHALL have port det_hit, input, 1 bit: Mealy detector output, combinational on det_bit in the same cycle.
REQ-012 SHALL have port done, output, 1 bit: one-cycle end-of-burst pulse.
REQ-013 SHALL have port cnt_sel, input, 2 bits: selects the requester whose hit counter is shown.
REQ-014 SHALL have port cnt_clr, input, 1 bit: synchronous clear of all hit counters.
REQ-015 SHALL have port hit_cnt, output, CNT_W bits: hit counter of requester cnt_sel, combinational mux.

Function
REQ-016 SHALL implement an FSM with states IDLE, CLEAR, STREAM and DONE.
REQ-017 IDLE: with any req bit set, SHALL pick a winner round-robin, searching upward from (last granted + 1) mod 4, then SHALL enter CLEAR and register gnt to the winner's one-hot code.
REQ-018 CLEAR: SHALL assert det_clr=1 for exactly one cycle, zero the bit counter, then enter STREAM.
REQ-019 STREAM: SHALL drive det_vld=req[g] and det_bit=din[g] (g = granted index); with det_vld=1, SHALL increment the bit counter.
REQ-020 STREAM: after the bit with counter value BURST_LEN-1 is sent, SHALL enter DONE.
REQ-021 STREAM: if req[g]=0, SHALL drive det_vld=0 that cycle, count no bit, and enter DONE (abort).
REQ-022 DONE: SHALL assert done=1 for one cycle, clear gnt, record g as last granted, and return to IDLE.
REQ-023 Latency: req seen in IDLE at cycle t gives gnt/det_clr at t+1, the first det_vld at t+2, and done at t+2+BURST_LEN.
REQ-024 SHALL spend at least one IDLE cycle between bursts; req changes outside IDLE are ignored except per REQ-021.
REQ-025 When det_vld=1 and det_hit=1, SHALL increment hit counter g, saturating at 2^CNT_W-1; det_hit SHALL be ignored when det_vld=0.
REQ-026 When cnt_clr=1 in the same cycle as a hit, the clear SHALL win and the counter SHALL become 0.
REQ-027 Outside STREAM, det_vld and det_bit SHALL be 0; gnt SHALL be non-zero only in CLEAR, STREAM and DONE.

Reset
REQ-028 While rst=1, SHALL force state IDLE, gnt=0, det_clr=0, det_vld=0, det_bit=0, done=0, bit counter 0, all hit counters 0, and last-granted=3 so that requester 0 wins first.
REQ-029 Reset during CLEAR or STREAM SHALL abort immediately, with no done pulse.

Configuration
REQ-030 With macro DET_SHARE_PRIO_EN defined, req[0] SHALL win arbitration in IDLE whenever it is set; the other requesters SHALL arbitrate round-robin among themselves.
REQ-031 Without DET_SHARE_PRIO_EN, all four requesters SHALL use pure round-robin per REQ-017.

Verification
REQ-032 Hold req=0010 with din[1] carrying 1101101101101101 -> gnt=0010 at t+1, det_clr pulse at t+1, 16 det_vld cycles, done at t+18, hit_cnt(sel=1) equals the number of det_hit pulses seen.
REQ-033 Hold req=1111 from reset -> grant order 0,1,2,3,0, each burst separated by one IDLE cycle.
REQ-034 Drop req[2] after 5 bits of its burst -> exactly 5 det_vld cycles, done the next cycle, gnt=0 after DONE.
REQ-035 Drive 20 hits to requester 3 with CNT_W=4 -> hit_cnt(sel=3)=15; then cnt_clr=1 together with a hit -> 0.
REQ-036 Assert rst in mid-STREAM -> gnt, det_vld and done go 0 asynchronously; no done pulse; the next grant goes to requester 0.
REQ-037 With DET_SHARE_PRIO_EN, hold req=1001 -> every burst grants requester 0; without the macro, grants alternate 0,3.
